regfile_writeback: RTL and testbench
====================================

# regfile_writeback

Write-back arbiter that sits in front of the 32x32 register file's single write port and is its only driver. It merges results from the single-cycle ALU path and the variable-latency load/multiply path (LSU port) onto `reg_write_enable`/`reg_write_addr`/`reg_write_data`. The LSU path is buffered in a small FIFO with a valid/ready handshake. Writes to `$0` are suppressed, and a starvation guard keeps a continuous ALU stream from blocking LSU results.

## Interface
- `FIFO_DEPTH`, default 4: LSU buffer entries; power of two, 2..16.
- `STARVE_LIMIT`, default 8: consecutive cycles the FIFO head may wait before `alu_stall` is raised; range 1..255.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `alu_valid` in 1: ALU result present this cycle. There is no ready signal; the ALU result is always taken unless `alu_stall`=1.
- `alu_addr` in 5: ALU destination register.
- `alu_data` in 32: ALU result.
- `lsu_valid` in 1: LSU result offered.
- `lsu_ready` out 1: LSU result accepted on a cycle where `lsu_valid` and `lsu_ready` are both 1.
- `lsu_addr` in 5: LSU destination register.
- `lsu_data` in 32: LSU result.
- `alu_stall` out 1: registered request that upstream hold the ALU for one cycle.
- `reg_write_enable` out 1: register file write strobe.
- `reg_write_addr` out 5: register file write address.
- `reg_write_data` out 32: register file write data.
- `fifo_count` out $clog2(FIFO_DEPTH)+1: number of occupied FIFO entries.
- `byp_addr1`, `byp_addr2` in 5 each: bypass lookup addresses.
- `byp_hit1`, `byp_hit2` out 1 each: bypass match flags.
- `byp_data1`, `byp_data2` out 32 each: bypass data.

## Operation
- **Output stage.** A single register drives `reg_write_*`. Each cycle it loads one selected write, or it loads enable=0 if nothing is selected.
- **Selection priority, highest first:**
  1. When `alu_stall`=1 and the FIFO is non-empty, the FIFO head is popped and the ALU input is ignored. The upstream contract requires `alu_valid`=0 on that cycle.
  2. When `alu_valid`=1 and `alu_addr`≠0, the ALU result is written.
  3. When the FIFO is non-empty, the FIFO head is popped.
  4. Otherwise the stage is idle.
- **ALU writes to `$0`.** When `alu_valid`=1 and `alu_addr`=0, the ALU input is treated as not valid, so the FIFO may pop that cycle.
- **LSU handshake.**
  - `lsu_ready` = !`rst` && (`fifo_count` < `FIFO_DEPTH`).
  - `lsu_ready` depends only on registered count. When the FIFO is full, a same-cycle pop does not admit a push.
  - An accepted LSU result with `lsu_addr`=0 completes the handshake but is not pushed.
- **FIFO.** Circular buffer with read and write pointers that wrap at `FIFO_DEPTH`. A push and a pop in the same cycle leave the count unchanged. An entry pushed at cycle N is poppable no earlier than cycle N+1.
- **Starvation counter.**
  - Increments on every cycle where the FIFO is non-empty and no pop occurs.
  - Clears on any pop, and on any cycle where the FIFO is empty.
  - When the counter equals `STARVE_LIMIT`, `alu_stall` goes high on the next cycle for exactly one cycle, and the counter clears.
- **Ordering.** Writes to the same register from both ports are ordered by the pipeline control, not by this block. Within the LSU port, writes leave in FIFO (arrival) order.

## Timing
- **Reset.** While `rst`=1, the following are held at 0: `reg_write_enable`, `reg_write_addr`, `reg_write_data`, `lsu_ready`, `alu_stall`, `fifo_count`, the starvation counter, the FIFO pointers, and all `byp_*` outputs. Reset asserted mid-operation discards all FIFO contents and any in-flight output.
- **Latency.** ALU input at cycle N produces a write at N+1. An LSU input accepted at N produces a write at N+2 at the earliest.
- **Write strobe.** `reg_write_enable` is high for exactly one cycle per write, and is never high with `reg_write_addr`=0.
- **Throughput.** One register write per cycle, sustained.

## Configuration
- `WB_BYPASS_EN` defined:
  - `byp_hitK` = `reg_write_enable` && (`reg_write_addr` == `byp_addrK`).
  - `byp_dataK` = `reg_write_data` when hit, else 0.
  - Both outputs are combinational. This covers the register file's read-before-write on the write cycle.
- `WB_BYPASS_EN` undefined: all `byp_*` outputs are tied to 0. The ports remain present.

## Test plan
- **Reset.** Hold `rst` for 2 cycles → all outputs are 0 and `lsu_ready`=0 during reset. On the first cycle after reset, `lsu_ready`=1 and `fifo_count`=0.
- **ALU write.** `alu_valid`, `alu_addr`=5, `alu_data`=0x00001234 at cycle N → at N+1, `reg_write_enable`=1, addr 5, data 0x00001234. At N+2, `reg_write_enable`=0.
- **Simultaneous ALU and LSU.** At cycle N, ALU writes r3=0xAAAA0000 and LSU writes r7=0x5555FFFF → r3 is written at N+1 and r7 at N+2.
- **Full FIFO and starvation.** With `STARVE_LIMIT`=8, drive continuous `alu_valid` with addr≠0 and push 4 LSU results → `lsu_ready`=0 at count 4. `alu_stall` pulses once after 8 waiting cycles, and the LSU head is written on the following cycle.
- **`$0` suppression.** ALU write with addr 0 → no write. LSU write with addr 0 → handshake completes and `fifo_count` is unchanged.
- **Bypass.** Output stage writing r9=0xDEADBEEF with `byp_addr1`=9 and `byp_addr2`=4 → `byp_hit1`=1, `byp_data1`=0xDEADBEEF, `byp_hit2`=0. Without `WB_BYPASS_EN`, all `byp_*` outputs are 0.

Source files
------------

// File: rtl/regfile_writeback_if.sv
// Interface bundling the ALU, LSU, register-file write and bypass signals
// of the write-back arbiter. The slave modport is the arbiter side. The master
// modport is the pipeline/register-file side.
interface regfile_writeback_if #(
  parameter int FIFO_DEPTH = 4
) ();
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic              alu_valid;
  logic [4:0]        alu_addr;
  logic [31:0]       alu_data;
  logic              alu_stall;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [4:0]        lsu_addr;
  logic [31:0]       lsu_data;

  logic              reg_write_enable;
  logic [4:0]        reg_write_addr;
  logic [31:0]       reg_write_data;
  logic [CNT_W-1:0]  fifo_count;

  logic [4:0]        byp_addr1;
  logic [4:0]        byp_addr2;
  logic              byp_hit1;
  logic              byp_hit2;
  logic [31:0]       byp_data1;
  logic [31:0]       byp_data2;

  modport master (
    output alu_valid, alu_addr, alu_data,
    output lsu_valid, lsu_addr, lsu_data,
    output byp_addr1, byp_addr2,
    input  alu_stall, lsu_ready,
    input  reg_write_enable, reg_write_addr, reg_write_data, fifo_count,
    input  byp_hit1, byp_hit2, byp_data1, byp_data2
  );

  modport slave (
    input  alu_valid, alu_addr, alu_data,
    input  lsu_valid, lsu_addr, lsu_data,
    input  byp_addr1, byp_addr2,
    output alu_stall, lsu_ready,
    output reg_write_enable, reg_write_addr, reg_write_data, fifo_count,
    output byp_hit1, byp_hit2, byp_data1, byp_data2
  );
endinterface

// File: rtl/regfile_writeback.sv
// Write-back arbiter: the only driver of the register file write port.
// Merges single-cycle ALU results with buffered LSU results. Writes to $0
// are dropped. A starvation counter raises alu_stall so that a continuous
// ALU stream cannot block the LSU FIFO head forever.
// Optional feature macro: WB_BYPASS_EN (combinational write-cycle bypass).
module regfile_writeback #(
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic               clk,
  input  logic               rst,
  regfile_writeback_if.slave bus
);
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;

  // LSU buffer storage (data only, never reset) and its control state
  logic [ADDR_W-1:0] r_fifo_addr [FIFO_DEPTH];
  logic [DATA_W-1:0] r_fifo_data [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_starve_cnt;
  logic              r_alu_stall;

  // Output stage registers
  logic              r_wr_vld_p1;
  logic [ADDR_W-1:0] r_wr_addr_p1;
  logic [DATA_W-1:0] r_wr_data_p1;

  logic w_fifo_empty;
  logic w_lsu_ready;
  logic w_push;
  logic w_alu_ok;
  logic w_stall_pop;
  logic w_pop;
  logic w_hit1;
  logic w_hit2;

  // Stage p0: selection. Readiness looks only at the registered count, so a
  // pop from a full FIFO never admits a push in the same cycle.
  assign w_fifo_empty = (r_count == '0);
  assign w_lsu_ready  = !rst && (r_count < CNT_W'(FIFO_DEPTH));
  assign w_push       = bus.lsu_valid && w_lsu_ready && (bus.lsu_addr != '0);
  assign w_alu_ok     = bus.alu_valid && (bus.alu_addr != '0);
  assign w_stall_pop  = r_alu_stall && !w_fifo_empty;
  assign w_pop        = w_stall_pop || (!w_alu_ok && !w_fifo_empty);

  // Store accepted LSU results at the write pointer
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_addr[r_wr_ptr] <= bus.lsu_addr;
      r_fifo_data[r_wr_ptr] <= bus.lsu_data;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at a power-of-two depth
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Starvation guard: count waiting cycles of a non-empty, unserved FIFO head
  // and issue a one-cycle alu_stall once the limit is reached
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starve_cnt <= '0;
      r_alu_stall  <= 1'b0;
    end else begin
      r_alu_stall <= (r_starve_cnt == 8'(STARVE_LIMIT));
      if (w_pop || w_fifo_empty || (r_starve_cnt == 8'(STARVE_LIMIT)))
        r_starve_cnt <= '0;
      else
        r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Stage p1: output register, loads the selected write or goes idle
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_vld_p1  <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end else if (w_pop) begin
      r_wr_vld_p1  <= 1'b1;
      r_wr_addr_p1 <= r_fifo_addr[r_rd_ptr];
      r_wr_data_p1 <= r_fifo_data[r_rd_ptr];
    end else if (w_alu_ok) begin
      r_wr_vld_p1  <= 1'b1;
      r_wr_addr_p1 <= bus.alu_addr;
      r_wr_data_p1 <= bus.alu_data;
    end else begin
      r_wr_vld_p1  <= 1'b0;
      r_wr_addr_p1 <= '0;
      r_wr_data_p1 <= '0;
    end
  end

  assign bus.reg_write_enable = r_wr_vld_p1;
  assign bus.reg_write_addr   = r_wr_addr_p1;
  assign bus.reg_write_data   = r_wr_data_p1;
  assign bus.lsu_ready        = w_lsu_ready;
  assign bus.alu_stall        = r_alu_stall;
  assign bus.fifo_count       = r_count;

`ifdef WB_BYPASS_EN
  // Forward the write in flight so a same-cycle register read sees it
  assign w_hit1 = r_wr_vld_p1 && (r_wr_addr_p1 == bus.byp_addr1);
  assign w_hit2 = r_wr_vld_p1 && (r_wr_addr_p1 == bus.byp_addr2);
  assign bus.byp_data1 = w_hit1 ? r_wr_data_p1 : '0;
  assign bus.byp_data2 = w_hit2 ? r_wr_data_p1 : '0;
`else
  logic w_unused_byp;
  assign w_unused_byp  = ^{bus.byp_addr1, bus.byp_addr2};
  assign w_hit1        = 1'b0;
  assign w_hit2        = 1'b0;
  assign bus.byp_data1 = '0;
  assign bus.byp_data2 = '0;
`endif
  assign bus.byp_hit1 = w_hit1;
  assign bus.byp_hit2 = w_hit2;

endmodule

// File: tb/tb_regfile_writeback.sv
// Directed bench for regfile_writeback (FIFO_DEPTH=4, STARVE_LIMIT=8).
// Bypass expectations follow WB_BYPASS_EN.
module tb_regfile_writeback;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  regfile_writeback_if #(.FIFO_DEPTH(4)) bus ();

  regfile_writeback #(.FIFO_DEPTH(4), .STARVE_LIMIT(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        v;
    logic [4:0]  a;
    logic [31:0] d;
    logic [4:0]  b1;
    logic [4:0]  b2;
    logic        en;
    logic [4:0]  ea;
    logic [31:0] ed;
    logic        h1;
    logic        h2;
  } vec_t;

  vec_t tbl [7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  function automatic logic byp_exp(input logic h);
`ifdef WB_BYPASS_EN
    return h;
`else
    return 1'b0 & h;
`endif
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = d;
  endtask

  task automatic set_lsu(input logic v, input logic [4:0] a, input logic [31:0] d);
    bus.lsu_valid = v;
    bus.lsu_addr  = a;
    bus.lsu_data  = d;
  endtask

  initial begin
    int stall_seen;
    logic h;
    n_cmp = 0;
    n_fail = 0;
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    bus.byp_addr1 = 5'd0;
    bus.byp_addr2 = 5'd0;

    //                 v  a      d             b1     b2     en ea     ed            h1 h2
    tbl[0] = '{1'b1, 5'd5,  32'h0000_1234, 5'd5,  5'd4,  1'b1, 5'd5,  32'h0000_1234, 1'b1, 1'b0};
    tbl[1] = '{1'b0, 5'd5,  32'h0000_9999, 5'd5,  5'd4,  1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[2] = '{1'b1, 5'd0,  32'h0000_FFFF, 5'd0,  5'd0,  1'b0, 5'd0,  32'h0,         1'b0, 1'b0};
    tbl[3] = '{1'b1, 5'd31, 32'hFFFF_FFFF, 5'd31, 5'd31, 1'b1, 5'd31, 32'hFFFF_FFFF, 1'b1, 1'b1};
    tbl[4] = '{1'b1, 5'd9,  32'hDEAD_BEEF, 5'd9,  5'd4,  1'b1, 5'd9,  32'hDEAD_BEEF, 1'b1, 1'b0};
    tbl[5] = '{1'b1, 5'd1,  32'h0000_0000, 5'd2,  5'd1,  1'b1, 5'd1,  32'h0000_0000, 1'b0, 1'b1};
    tbl[6] = '{1'b1, 5'd17, 32'h1357_9BDF, 5'd3,  5'd8,  1'b1, 5'd17, 32'h1357_9BDF, 1'b0, 1'b0};

    // Reset held for two cycles
    step();
    step();
    check("rst_en", {31'd0, bus.reg_write_enable}, 32'd0);
    check("rst_addr", {27'd0, bus.reg_write_addr}, 32'd0);
    check("rst_data", bus.reg_write_data, 32'd0);
    check("rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd0);
    check("rst_stall", {31'd0, bus.alu_stall}, 32'd0);
    check("rst_count", {29'd0, bus.fifo_count}, 32'd0);
    check("rst_byp", {bus.byp_hit1, bus.byp_hit2, 30'd0} | bus.byp_data1 | bus.byp_data2, 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    check("post_rst_count", {29'd0, bus.fifo_count}, 32'd0);

    // ALU vector table
    for (int i = 0; i < 7; i++) begin
      set_alu(tbl[i].v, tbl[i].a, tbl[i].d);
      step();
      bus.byp_addr1 = tbl[i].b1;
      bus.byp_addr2 = tbl[i].b2;
      #1;
      check($sformatf("vec%0d_en", i), {31'd0, bus.reg_write_enable}, {31'd0, tbl[i].en});
      if (tbl[i].en) begin
        check($sformatf("vec%0d_addr", i), {27'd0, bus.reg_write_addr}, {27'd0, tbl[i].ea});
        check($sformatf("vec%0d_data", i), bus.reg_write_data, tbl[i].ed);
      end
      h = byp_exp(tbl[i].h1);
      check($sformatf("vec%0d_hit1", i), {31'd0, bus.byp_hit1}, {31'd0, h});
      check($sformatf("vec%0d_bdata1", i), bus.byp_data1, h ? tbl[i].ed : 32'd0);
      h = byp_exp(tbl[i].h2);
      check($sformatf("vec%0d_hit2", i), {31'd0, bus.byp_hit2}, {31'd0, h});
      check($sformatf("vec%0d_bdata2", i), bus.byp_data2, h ? tbl[i].ed : 32'd0);
    end

    // Simultaneous ALU r3 and LSU r7: ALU first, LSU one cycle later
    set_alu(1'b1, 5'd3, 32'hAAAA_0000);
    set_lsu(1'b1, 5'd7, 32'h5555_FFFF);
    #1;
    check("sim_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    step();
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    check("sim_alu_en", {31'd0, bus.reg_write_enable}, 32'd1);
    check("sim_alu_addr", {27'd0, bus.reg_write_addr}, 32'd3);
    check("sim_alu_data", bus.reg_write_data, 32'hAAAA_0000);
    check("sim_count1", {29'd0, bus.fifo_count}, 32'd1);
    step();
    check("sim_lsu_en", {31'd0, bus.reg_write_enable}, 32'd1);
    check("sim_lsu_addr", {27'd0, bus.reg_write_addr}, 32'd7);
    check("sim_lsu_data", bus.reg_write_data, 32'h5555_FFFF);
    check("sim_count0", {29'd0, bus.fifo_count}, 32'd0);
    step();
    check("sim_idle_en", {31'd0, bus.reg_write_enable}, 32'd0);

    // $0 on both ports: no write, LSU handshake completes without a push
    set_alu(1'b1, 5'd0, 32'h1111_1111);
    set_lsu(1'b1, 5'd0, 32'h2222_2222);
    #1;
    check("zero_lsu_ready", {31'd0, bus.lsu_ready}, 32'd1);
    step();
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    check("zero_count", {29'd0, bus.fifo_count}, 32'd0);
    check("zero_en", {31'd0, bus.reg_write_enable}, 32'd0);
    step();
    check("zero_en2", {31'd0, bus.reg_write_enable}, 32'd0);

    // Full FIFO under a continuous ALU stream, then starvation stall
    stall_seen = 0;
    for (int i = 0; i < 10; i++) begin
      set_alu(1'b1, 5'd20, 32'h0000_0100 + i);
      if (i < 4) set_lsu(1'b1, 5'(10 + i), 32'hC0DE_0000 + i);
      else       set_lsu(1'b1, 5'd14, 32'h0000_0BAD);
      step();
      check($sformatf("stv%0d_alu_en", i), {31'd0, bus.reg_write_enable}, 32'd1);
      check($sformatf("stv%0d_alu_addr", i), {27'd0, bus.reg_write_addr}, 32'd20);
      check($sformatf("stv%0d_alu_data", i), bus.reg_write_data, 32'h0000_0100 + i);
      if (i >= 3) begin
        check($sformatf("stv%0d_count", i), {29'd0, bus.fifo_count}, 32'd4);
        check($sformatf("stv%0d_ready", i), {31'd0, bus.lsu_ready}, 32'd0);
      end
      if (bus.alu_stall) stall_seen++;
    end
    check("stv_stall_now", {31'd0, bus.alu_stall}, 32'd1);
    check("stv_stall_pulses", stall_seen, 32'd1);
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    step();
    check("stv_head_en", {31'd0, bus.reg_write_enable}, 32'd1);
    check("stv_head_addr", {27'd0, bus.reg_write_addr}, 32'd10);
    check("stv_head_data", bus.reg_write_data, 32'hC0DE_0000);
    check("stv_stall_drop", {31'd0, bus.alu_stall}, 32'd0);
    check("stv_count3", {29'd0, bus.fifo_count}, 32'd3);
    for (int k = 1; k < 4; k++) begin
      step();
      check($sformatf("drain%0d_addr", k), {27'd0, bus.reg_write_addr}, 32'(10 + k));
      check($sformatf("drain%0d_data", k), bus.reg_write_data, 32'hC0DE_0000 + k);
      check($sformatf("drain%0d_count", k), {29'd0, bus.fifo_count}, 32'(3 - k));
    end
    step();
    check("drain_idle_en", {31'd0, bus.reg_write_enable}, 32'd0);

    // Reset mid-operation discards buffered LSU results
    set_alu(1'b1, 5'd6, 32'h0000_0006);
    set_lsu(1'b1, 5'd21, 32'h0000_0021);
    step();
    set_lsu(1'b1, 5'd22, 32'h0000_0022);
    step();
    check("mid_count2", {29'd0, bus.fifo_count}, 32'd2);
    rst = 1'b1;
    set_alu(1'b0, 5'd0, 32'h0);
    set_lsu(1'b0, 5'd0, 32'h0);
    step();
    check("mid_rst_count", {29'd0, bus.fifo_count}, 32'd0);
    check("mid_rst_en", {31'd0, bus.reg_write_enable}, 32'd0);
    check("mid_rst_ready", {31'd0, bus.lsu_ready}, 32'd0);
    rst = 1'b0;
    step();
    check("mid_after_en", {31'd0, bus.reg_write_enable}, 32'd0);
    check("mid_after_count", {29'd0, bus.fifo_count}, 32'd0);
    step();
    check("mid_after_en2", {31'd0, bus.reg_write_enable}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
